// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (start, DATA_BITS data LSB first, stop).
// Samples each bit at its midpoint and strobes rx_done_tick for one clock per frame.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICKS   = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_err
);

  localparam int S_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_MID       = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_LAST_STOP = S_W'(SB_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               r_state, w_state_next;
  logic [S_W-1:0]       r_s, w_s_next;
  logic [N_W-1:0]       r_n, w_n_next;
  logic [DATA_BITS-1:0] r_b, w_b_next;
  logic [DATA_BITS-1:0] r_dout, w_dout_next;
  logic                 r_done, w_done_next;
  logic                 r_ferr, w_ferr_next;
  logic                 r_sync1, r_sync2;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_dout  <= w_dout_next;
      r_done  <= w_done_next;
      r_ferr  <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_dout_next  = r_dout;
    w_done_next  = 1'b0;
    w_ferr_next  = r_ferr;
    case (r_state)
      IDLE: begin
        if (!r_sync2) begin
          w_state_next = START;
          w_s_next     = '0;
        end
      end
      START: begin
        // A start bit that is high again at its midpoint was a glitch.
        if (s_tick) begin
          if (r_s == S_MID) begin
            if (!r_sync2) begin
              w_state_next = DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == S_LAST_BIT) begin
            w_s_next = '0;
            w_b_next = {r_sync2, r_b[DATA_BITS-1:1]};
            if (r_n == N_LAST) w_state_next = STOP;
            else               w_n_next     = r_n + 1'b1;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
        if (s_tick) begin
          if (r_s == S_LAST_STOP) begin
            w_state_next = IDLE;
            w_dout_next  = r_b;
            w_ferr_next  = ~r_sync2;
            w_done_next  = 1'b1;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8-bit and a 7-bit receiver fed by a shared tick,
// with hand-built frames and hand-computed expected words.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       s_tick = 1'b0;
  logic       tick_en = 1'b1;
  logic       reset8 = 1'b1, reset7 = 1'b1;
  logic       rx8 = 1'b1, rx7 = 1'b1;
  logic [7:0] dout8;
  logic [6:0] dout7;
  logic       done8, done7, ferr8, ferr7;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int tdiv     = 0;
  int start_cyc = 0;
  int done_cyc8 = 0;
  int done_cyc7 = 0;
  int lat;

  logic [7:0] q_d8[$];
  logic       q_f8[$];
  logic [6:0] q_d7[$];
  logic       q_f7[$];

  uart_rx #(.DATA_BITS(8), .SB_TICKS(16), .OVERSAMPLE(16)) dut8 (
    .clk(clk), .reset(reset8), .s_tick(s_tick), .rx(rx8),
    .dout(dout8), .rx_done_tick(done8), .frame_err(ferr8)
  );

  uart_rx #(.DATA_BITS(7), .SB_TICKS(16), .OVERSAMPLE(16)) dut7 (
    .clk(clk), .reset(reset7), .s_tick(s_tick), .rx(rx7),
    .dout(dout7), .rx_done_tick(done7), .frame_err(ferr7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One tick every 4 clocks, changed on the falling edge.
  always @(negedge clk) begin
    tdiv   = (tdiv == 3) ? 0 : tdiv + 1;
    s_tick = tick_en && (tdiv == 0);
  end

  always @(negedge clk) begin
    if (done8) begin
      q_d8.push_back(dout8);
      q_f8.push_back(ferr8);
      done_cyc8 = cyc;
    end
    if (done7) begin
      q_d7.push_back(dout7);
      q_f7.push_back(ferr7);
      done_cyc7 = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 8) rx8 = v;
    else            rx7 = v;
  endtask

  // One frame of 64-clock bits; freeze_bit stretches that bit with ticks stopped.
  // A stop bit shorter than 64 clocks is followed by high for the remainder.
  task automatic send(input int which, input logic [8:0] d, input int nbits,
                      input logic stop_v, input int stop_clk, input int freeze_bit);
    set_rx(which, 1'b0);
    start_cyc = cyc;
    wait_clk(64);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, d[i]);
      if (i == freeze_bit) begin
        wait_clk(32);
        tick_en = 1'b0;
        wait_clk(100);
        tick_en = 1'b1;
        wait_clk(32);
      end else begin
        wait_clk(64);
      end
    end
    set_rx(which, stop_v);
    wait_clk(stop_clk);
    set_rx(which, 1'b1);
    if (stop_clk < 64) wait_clk(64 - stop_clk);
  endtask

  task automatic pop8(input string tag, input logic [7:0] d, input logic fe);
    chk({tag, "_avail"}, 32'(q_d8.size() > 0), 32'd1);
    if (q_d8.size() > 0) begin
      chk({tag, "_dout"}, 32'(q_d8.pop_front()), 32'(d));
      chk({tag, "_ferr"}, 32'(q_f8.pop_front()), 32'(fe));
    end
  endtask

  task automatic pop7(input string tag, input logic [6:0] d, input logic fe);
    chk({tag, "_avail"}, 32'(q_d7.size() > 0), 32'd1);
    if (q_d7.size() > 0) begin
      chk({tag, "_dout"}, 32'(q_d7.pop_front()), 32'(d));
      chk({tag, "_ferr"}, 32'(q_f7.pop_front()), 32'(fe));
    end
  endtask

  initial begin
    wait_clk(8);
    chk("rst_dout8", 32'(dout8), 32'h0);
    chk("rst_done8", 32'(done8), 32'h0);
    chk("rst_ferr8", 32'(ferr8), 32'h0);
    chk("rst_dout7", 32'(dout7), 32'h0);
    reset8 = 1'b0;
    reset7 = 1'b0;
    wait_clk(64);

    // 0xA5: done about 9.5 bit periods (608 clocks) after the start edge.
    send(8, 9'h0A5, 8, 1'b1, 64, -1);
    chk("a5_count", 32'(q_d8.size()), 32'd1);
    lat = done_cyc8 - start_cyc;
    chk("a5_latency_ok", 32'(lat >= 600 && lat <= 620), 32'd1);
    pop8("a5", 8'hA5, 1'b0);

    // Start glitch of 4 ticks is rejected.
    rx8 = 1'b0;
    wait_clk(16);
    rx8 = 1'b1;
    wait_clk(128);
    chk("glitch_count", 32'(q_d8.size()), 32'd0);
    chk("glitch_dout", 32'(dout8), 32'hA5);

    // Bad stop bit, held low past the sample point, then a clean frame.
    send(8, 9'h03C, 8, 1'b0, 48, -1);
    chk("3c_count", 32'(q_d8.size()), 32'd1);
    pop8("3c", 8'h3C, 1'b1);
    chk("3c_ferr_hold", 32'(ferr8), 32'd1);
    wait_clk(128);
    send(8, 9'h081, 8, 1'b1, 64, -1);
    pop8("81", 8'h81, 1'b0);

    // Back-to-back frames with no idle gap.
    send(8, 9'h000, 8, 1'b1, 64, -1);
    send(8, 9'h0FF, 8, 1'b1, 64, -1);
    send(8, 9'h055, 8, 1'b1, 64, -1);
    chk("b2b_count", 32'(q_d8.size()), 32'd3);
    pop8("b2b0", 8'h00, 1'b0);
    pop8("b2b1", 8'hFF, 1'b0);
    pop8("b2b2", 8'h55, 1'b0);

    // Reset in the middle of data bit 4 of a 0x7E frame.
    rx8 = 1'b0;
    wait_clk(64);
    rx8 = 1'b0; wait_clk(64);
    rx8 = 1'b1; wait_clk(64);
    rx8 = 1'b1; wait_clk(64);
    rx8 = 1'b1; wait_clk(64);
    rx8 = 1'b1; wait_clk(32);
    reset8 = 1'b1;
    wait_clk(2);
    reset8 = 1'b0;
    wait_clk(1);
    chk("midrst_dout", 32'(dout8), 32'h0);
    chk("midrst_done", 32'(done8), 32'h0);
    chk("midrst_ferr", 32'(ferr8), 32'h0);
    rx8 = 1'b1;
    wait_clk(128);
    chk("midrst_nodone", 32'(q_d8.size()), 32'd0);
    send(8, 9'h07E, 8, 1'b1, 64, -1);
    pop8("7e", 8'h7E, 1'b0);

    // 7-bit receiver: done 8.5 bit periods (544 clocks) after the start edge.
    send(7, 9'h05A, 7, 1'b1, 64, -1);
    chk("w7_count", 32'(q_d7.size()), 32'd1);
    lat = done_cyc7 - start_cyc;
    chk("w7_latency_ok", 32'(lat >= 536 && lat <= 556), 32'd1);
    pop7("w7_5a", 7'h5A, 1'b0);

    // Ticks stopped for 100 clocks mid-frame; the frame still completes.
    send(7, 9'h033, 7, 1'b1, 64, 3);
    chk("freeze_count", 32'(q_d7.size()), 32'd1);
    pop7("freeze_33", 7'h33, 1'b0);
    chk("freeze_dut8_quiet", 32'(q_d8.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
